// File: rtl/hh_pkg.sv
// Shared types, fixed-point constants and arithmetic helpers for the HH membrane integrator.
package hh_pkg;

  typedef enum logic [3:0] {IDLE, M2, M3, MH, INA, N2, N4, IK, IL, INT} state_t;

  localparam int SCALE_RECIP = 1049;
  localparam int SCALE_SHIFT = 20;
  localparam int Q_FRAC      = 8;
  localparam int GATE_ONE    = 1000;

  localparam logic [1:0] MUL_RAW   = 2'd0;
  localparam logic [1:0] MUL_Q8    = 2'd1;
  localparam logic [1:0] MUL_SCALE = 2'd2;

  localparam logic signed [15:0] DEF_G_NA   = 16'sd30720;
  localparam logic signed [15:0] DEF_G_K    = 16'sd9216;
  localparam logic signed [15:0] DEF_G_L    = 16'sd77;
  localparam logic signed [15:0] DEF_E_NA   = 16'sd12800;
  localparam logic signed [15:0] DEF_E_K    = -16'sd19712;
  localparam logic signed [15:0] DEF_E_L    = -16'sd13926;
  localparam logic signed [15:0] DEF_V_INIT = -16'sd16640;

  function automatic logic signed [47:0] sx16(input logic signed [15:0] x);
    return {{32{x[15]}}, x};
  endfunction

  // Full-precision 96-bit product, arithmetic shift, then keep the low 48 bits.
  function automatic logic signed [47:0] mul_sh(input logic signed [47:0] a,
                                                input logic signed [47:0] b,
                                                input int unsigned sh);
    logic signed [95:0] ea, eb;
    ea = {{48{a[47]}}, a};
    eb = {{48{b[47]}}, b};
    return 48'((ea * eb) >>> sh);
  endfunction

  // Approximate divide by 1000: (x*1049) >>> 20.
  function automatic logic signed [47:0] scale_down(input logic signed [47:0] x);
    return mul_sh(x, 48'(SCALE_RECIP), SCALE_SHIFT);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [47:0] x);
    if (x > 48'sd32767)  return 16'sh7fff;
    if (x < -48'sd32768) return 16'sh8000;
    return x[15:0];
  endfunction

  function automatic logic signed [15:0] clamp_gate(input logic signed [15:0] g);
    if (g < 16'sd0)           return 16'sd0;
    if (g > 16'(GATE_ONE))    return 16'(GATE_ONE);
    return g;
  endfunction

endpackage

// File: rtl/hh_mul_scale.sv
// Single shared signed multiplier with selectable post-shift, one register stage.
module hh_mul_scale
  import hh_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [47:0] a,
  input  logic signed [47:0] b,
  input  logic [1:0]         mode,
  output logic signed [47:0] p
);

  logic signed [47:0] p_nx;

  always_comb begin
    unique case (mode)
      MUL_Q8:    p_nx = mul_sh(a, b, Q_FRAC);
      MUL_SCALE: p_nx = scale_down(mul_sh(a, b, 0));
      default:   p_nx = mul_sh(a, b, 0);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= '0;
    else          p <= p_nx;
  end

endmodule

// File: rtl/update_v.sv
// HH membrane-potential integrator: sequenced ionic currents + one forward-Euler step.
// UPDATE_V_LEAK_EN adds the IL state and the leak current (latency 9 instead of 8).
module update_v
  import hh_pkg::*;
#(
  parameter logic signed [15:0] G_NA   = DEF_G_NA,
  parameter logic signed [15:0] G_K    = DEF_G_K,
  parameter logic signed [15:0] G_L    = DEF_G_L,
  parameter logic signed [15:0] E_NA   = DEF_E_NA,
  parameter logic signed [15:0] E_K    = DEF_E_K,
  parameter logic signed [15:0] E_L    = DEF_E_L,
  parameter logic signed [15:0] V_INIT = DEF_V_INIT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic signed [15:0] m,
  input  logic signed [15:0] h,
  input  logic signed [15:0] n,
  input  logic [15:0]        dt,
  input  logic signed [15:0] i_ext,
  output logic               busy,
  output logic               v_valid,
  output logic signed [15:0] v_q8,
  output logic signed [15:0] v_mv
);

  state_t state, state_nx;

  logic signed [15:0] gm, gh, gn, iext_r;
  logic [15:0]        dt_r;
  logic signed [47:0] acc, p, vx;
  logic signed [47:0] mul_a, mul_b, drive, drv, i_sum, i_net, dv;
  logic [1:0]         mul_mode;
  logic signed [15:0] v_nx;

  hh_mul_scale u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (mul_a),
    .b       (mul_b),
    .mode    (mul_mode),
    .p       (p)
  );

  assign vx   = sx16(v_q8);
  assign busy = (state != IDLE);
  assign v_mv = v_q8 >>> Q_FRAC;

  // Each state issues one multiply; the previous issue's result sits in p.
  always_comb begin
    state_nx = state;
    mul_a    = '0;
    mul_b    = '0;
    mul_mode = MUL_SCALE;
    drive    = '0;
    unique case (state)
      IDLE: if (start) state_nx = M2;
      M2:  begin mul_a = sx16(gm);   mul_b = sx16(gm); state_nx = M3;  end
      M3:  begin mul_a = p;          mul_b = sx16(gm); state_nx = MH;  end
      MH:  begin mul_a = p;          mul_b = sx16(gh); state_nx = INA; end
      INA: begin mul_a = sx16(G_NA); mul_b = p;        state_nx = N2;  end
      N2: begin
        mul_a = sx16(gn); mul_b = sx16(gn);
        drive = vx - sx16(E_NA);
        state_nx = N4;
      end
      N4:  begin mul_a = p; mul_b = p; state_nx = IK; end
      IK: begin
        mul_a = sx16(G_K); mul_b = p;
`ifdef UPDATE_V_LEAK_EN
        state_nx = IL;
`else
        state_nx = INT;
`endif
      end
      IL: begin
        mul_a = sx16(G_L); mul_b = vx - sx16(E_L); mul_mode = MUL_Q8;
        drive = vx - sx16(E_K);
        state_nx = INT;
      end
      INT: begin drive = vx - sx16(E_K); state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  // Driving-force product: conductance term in p times (v - E), back to Q8.
  assign drv = mul_sh(p, drive, Q_FRAC);

`ifdef UPDATE_V_LEAK_EN
  assign i_sum = acc + p;
`else
  assign i_sum = acc + drv;
`endif
  assign i_net = sx16(iext_r) - i_sum;
  assign dv    = scale_down(mul_sh(i_net, {32'd0, dt_r}, 0));
  assign v_nx  = sat16(vx + dv);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      v_q8    <= V_INIT;
      v_valid <= 1'b0;
      acc     <= '0;
      gm      <= '0;
      gh      <= '0;
      gn      <= '0;
      dt_r    <= '0;
      iext_r  <= '0;
    end else begin
      state   <= state_nx;
      v_valid <= (state == INT);
      unique case (state)
        IDLE: if (start) begin
          gm     <= clamp_gate(m);
          gh     <= clamp_gate(h);
          gn     <= clamp_gate(n);
          dt_r   <= dt;
          iext_r <= i_ext;
          acc    <= '0;
        end
        N2, IL: acc <= acc + drv;
        INT:    v_q8 <= v_nx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_update_v.sv
// Randomized self-checking bench for update_v against an arithmetic reference model.
module tb_update_v;

`ifdef UPDATE_V_LEAK_EN
  localparam int LAT  = 9;
  localparam bit LEAK = 1'b1;
`else
  localparam int LAT  = 8;
  localparam bit LEAK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] m = '0, h = '0, n = '0, i_ext = '0;
  logic [15:0]        dt = '0;
  logic               busy, v_valid;
  logic signed [15:0] v_q8, v_mv;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint model_v = -16640;

  update_v dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .m       (m),
    .h       (h),
    .n       (n),
    .dt      (dt),
    .i_ext   (i_ext),
    .busy    (busy),
    .v_valid (v_valid),
    .v_q8    (v_q8),
    .v_mv    (v_mv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sd(input longint x);
    return (x * 1049) >>> 20;
  endfunction

  function automatic longint clampg(input longint g);
    return (g < 0) ? 0 : ((g > 1000) ? 1000 : g);
  endfunction

  // One Euler step computed directly from the current equations.
  function automatic longint ref_v(input longint v, input longint mi, input longint hi,
                                   input longint ni, input longint dti, input longint ie);
    longint mm, hh, nn, gna, gk, ina, ik, il, inet, nv;
    mm   = clampg(mi);
    hh   = clampg(hi);
    nn   = clampg(ni);
    gna  = sd(30720 * sd(sd(sd(mm * mm) * mm) * hh));
    ina  = (gna * (v - 12800)) >>> 8;
    gk   = sd(9216 * sd(sd(nn * nn) * sd(nn * nn)));
    ik   = (gk * (v + 19712)) >>> 8;
    il   = LEAK ? ((77 * (v + 13926)) >>> 8) : 0;
    inet = ie - (ina + ik + il);
    nv   = v + sd(inet * dti);
    if (nv > 32767)       nv = 32767;
    else if (nv < -32768) nv = -32768;
    return nv;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_v = -16640;
  endtask

  task automatic step(input string tag, input logic signed [15:0] mi, input logic signed [15:0] hi,
                      input logic signed [15:0] ni, input logic [15:0] dti,
                      input logic signed [15:0] ie);
    int     k;
    longint ev;
    @(negedge clk);
    m = mi; h = hi; n = ni; dt = dti; i_ext = ie; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble inputs: the step must use only the values latched at accept
    m = 16'($urandom); h = 16'($urandom); n = 16'($urandom);
    dt = 16'($urandom); i_ext = 16'($urandom);
    ev = ref_v(model_v, mi, hi, ni, dti, ie);
    chk({tag, "/busy"}, busy, 1);
    k = 0;
    while (!v_valid && k < 20) begin
      chk({tag, "/hold"}, v_q8, model_v);
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "/latency"}, k, LAT);
    chk({tag, "/v_q8"}, v_q8, ev);
    chk({tag, "/v_mv"}, v_mv, ev >>> 8);
    chk({tag, "/idle"}, busy, 0);
    model_v = ev;
    @(posedge clk); #1;
    chk({tag, "/pulse"}, v_valid, 0);
  endtask

  initial begin
    int  cnt, tmp_m, tmp_h, tmp_n, tmp_i;
    bit  exp_vld;

    // reset state
    #12;
    chk("rst/v_q8", v_q8, -16640);
    chk("rst/v_mv", v_mv, -65);
    chk("rst/busy", busy, 0);
    chk("rst/valid", v_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // dt = 0 leaves V unchanged but still pulses after full latency
    step("dt0", 16'sd53, 16'sd596, 16'sd318, 16'd0, 16'sd0);
    chk("dt0/const", v_q8, -16640);

    // leak only from rest
    step("leak", 16'sd0, 16'sd0, 16'sd0, 16'd1000, 16'sd0);
    chk("leak/const", v_q8, LEAK ? -15823 : -16640);
    chk("leak/mv", v_mv, LEAK ? -62 : -65);

    // gate clamp: out-of-range gates behave as their clamped values
    do_reset();
    step("clampA", 16'sd1500, 16'sd500, -16'sd20, 16'd200, 16'sd100);
    do_reset();
    step("clampB", 16'sd1000, 16'sd500, 16'sd0, 16'd200, 16'sd100);

    // randomized steps
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tmp_m = int'($urandom_range(1400)) - 200;
      tmp_h = int'($urandom_range(1400)) - 200;
      tmp_n = int'($urandom_range(1400)) - 200;
      tmp_i = int'($urandom_range(8000)) - 4000;
      step("rand", 16'(tmp_m), 16'(tmp_h), 16'(tmp_n), 16'($urandom_range(300)), 16'(tmp_i));
    end

    // saturation both ways, no wrap
    for (int i = 0; i < 3; i++) step("sat_hi", 16'sd0, 16'sd0, 16'sd0, 16'hffff, 16'sd32767);
    chk("sat_hi/pin", v_q8, 32767);
    for (int i = 0; i < 3; i++) step("sat_lo", 16'sd0, 16'sd0, 16'sd0, 16'hffff, -16'sd32768);
    chk("sat_lo/pin", v_q8, -32768);

    // reset in the middle of a step aborts it
    @(negedge clk);
    m = 16'sd300; h = 16'sd300; n = 16'sd300; dt = 16'd500; i_ext = 16'sd1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort/v_q8", v_q8, -16640);
    chk("abort/v_mv", v_mv, -65);
    chk("abort/busy", busy, 0);
    chk("abort/valid", v_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_v = -16640;
    cnt = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (v_valid) cnt++;
    end
    chk("abort/no_valid", cnt, 0);

    // start held high for 40 edges: back-to-back steps, no extras
    @(negedge clk);
    m = 16'sd100; h = 16'sd600; n = 16'sd300; dt = 16'd50; i_ext = 16'sd2560; start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (e == 39) start = 1'b0;
      exp_vld = (e >= LAT) && ((e - LAT) % (LAT + 1) == 0) && (e - LAT <= 39);
      chk($sformatf("hs/valid@E%0d", e), v_valid, exp_vld);
      if (exp_vld) begin
        model_v = ref_v(model_v, 100, 600, 300, 50, 2560);
        chk($sformatf("hs/v_q8@E%0d", e), v_q8, model_v);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/update_v.md
# update_v

Membrane-potential integrator for the Hodgkin-Huxley neuron: the consuming end of the V→gate interface. It takes the gating variables m, h and n (scaled ×1000) and computes the Na, K and leak currents with one shared multiplier. It then applies one forward-Euler step to V and publishes the new V back to the gate updaters. It sits between the m/h/n gate blocks and the spike/output logic.

## Interface
- G_NA, default 30720: Na conductance, mS/cm² Q8 (120.0)
- G_K, default 9216: K conductance, mS/cm² Q8 (36.0)
- G_L, default 77: leak conductance, mS/cm² Q8 (0.3)
- E_NA, E_K, E_L, defaults 12800, −19712, −13926: reversal potentials, mV Q8 (50, −77, −54.4)
- V_INIT, default −16640: reset potential, mV Q8 (−65)
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request one Euler step; accepted only when busy=0
- m, h, n  in  16 signed  gating variables ×1000
- dt  in  16 unsigned  time step, ms ×1000
- i_ext  in  16 signed  injected current, µA/cm² Q8
- busy  out  1  step in progress
- v_valid  out  1  one-cycle pulse: new V published
- v_q8  out  16 signed  membrane potential, mV Q8
- v_mv  out  16 signed  v_q8 >>> 8 (floor), integer mV for the gate blocks

## Operation
- Reset values: v_q8=V_INIT, v_mv=−65, busy=0, v_valid=0, FSM=IDLE.
- At the accepting edge, m/h/n/dt/i_ext are latched. Gates are clamped to [0,1000] on latch.
- scale_down(x) = (x·1049) >>> 20, an approximate divide by 1000. Every gate×gate and G×gate product is rescaled by scale_down.
- States, one multiply each:
  - IDLE
  - M2: m·m
  - M3: ·m
  - MH: ·h
  - INA: G_NA·mh, then ·(v−E_NA) >>> 8
  - N2: n·n
  - N4: n2·n2
  - IK: G_K·n4, then ·(v−E_K) >>> 8
  - IL: G_L·(v−E_L) >>> 8
  - INT
  - Return to IDLE.
- INA and IK each take 2 products in one cycle. The shared multiplier is pipelined as multiply→shift, so each state holds one multiplier issue plus one accumulate.
- INT computes I_net = i_ext − (I_Na+I_K+I_L), then dv = scale_down(I_net·dt) with C_M = 1, then v_q8 ← sat16(v_q8+dv).
- Intermediates are 48-bit signed. Saturate to the 16-bit range; never wrap.
- start while busy is ignored with no queuing. Inputs are not re-sampled mid-step.

## Timing
- Accept at edge E0. busy=1 from E0 through E9.
- At E9, v_q8 and v_mv update, v_valid=1 for exactly one cycle, and busy=0.
- start high in the v_valid cycle is accepted at E10, giving a back-to-back period of 10 cycles.
- v_q8 and v_mv change only at the E9 edge.
- reset_n low at any point aborts the step immediately and restores all reset values. No v_valid is issued for the aborted step.
- dt=0: the full latency still applies, v_valid still pulses, and V is unchanged.

## Configuration
- UPDATE_V_LEAK_EN defined: the IL state exists and the leak current is included. Latency is 9 edges, period 10.
- UPDATE_V_LEAK_EN undefined: IL is skipped, I_L=0, and the G_L/E_L parameters are unused. Latency is 8 edges, period 9; v_valid pulses at E8.

## Structure
- Package hh_pkg holds:
  - the FSM state enum
  - the scale constants (SCALE_RECIP=1049, SCALE_SHIFT=20, Q_FRAC=8, GATE_ONE=1000)
  - default conductances and reversal potentials
  - the scale_down and sat16 functions
- Sub-module hh_mul_scale holds the single shared signed multiplier, with selectable post-shift (none, >>>8, or scale_down). It is registered one stage.

## Test plan
- Reset: reset_n low → v_q8=−16640, v_mv=−65, busy=0, v_valid=0. Assert reset_n low mid-step (E4) → same values, and no v_valid follows.
- dt=0, m=53, h=596, n=318, i_ext=0, start → v_valid exactly at E9 (E8 without the macro), v_q8=−16640.
- Leak only (m=0, n=0, h=0, i_ext=0, dt=1000) from rest → I_L=−817, dv=817, v_q8=−15823, v_mv=−62.
- Saturation: i_ext=32767, dt=65535, gates 0, repeated steps → v_q8 pins at 32767 with no wrap. Then i_ext=−32768 → pins at −32768.
- Handshake: start held high for 40 cycles → v_valid at E9, E19, E29, E39. Extra start pulses during busy produce no extra steps.
- Gate clamp: m=1500, n=−20 → identical result to m=1000, n=0.
